sub_diff_accum: RTL and testbench

- Downstream consumer of the 8-bit subtractor output.
- Accepts a stream of differences over a valid/ready handshake and interprets each as two's-complement signed.
- Accumulates a saturating signed sum over fixed-length frames, counts negative samples per frame, and emits one result word per frame over a second valid/ready handshake.
- Used for frame-level statistics on subtractor results, e.g. sweep checking.

---
 rtl/sub_pkg.sv | 27 ++
 rtl/sub_diff_accum_sat_add.sv | 36 +++
 rtl/sub_diff_accum.sv | 89 ++++++++
 tb/tb_sub_diff_accum.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared constants, saturation helpers and the result bundle type for the
// subtractor-difference frame accumulator.
package sub_pkg;

  localparam int DIFF_W    = 8;
  localparam int SUM_W_DEF = 16;
  localparam int NEG_W     = 8;

  // Limits come back 32 bits wide; callers truncate to their own SUM_W (<= 32).
  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

  localparam logic [SUM_W_DEF-1:0] SAT_MAX_DEF = SUM_W_DEF'(sat_max(SUM_W_DEF));
  localparam logic [SUM_W_DEF-1:0] SAT_MIN_DEF = SUM_W_DEF'(sat_min(SUM_W_DEF));

  typedef struct packed {
    logic signed [SUM_W_DEF-1:0] sum;
    logic [NEG_W-1:0]            neg_cnt;
    logic                        sat;
  } diff_result_t;

endpackage

// File: rtl/sub_diff_accum_sat_add.sv
// Combinational saturating add of a signed SUM_W accumulator and a
// sign-extended DATA_W operand; reports whether clamping happened.
module sat_add_signed
  import sub_pkg::*;
#(
  parameter int DATA_W = DIFF_W,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic [SUM_W-1:0]  acc,
  input  logic [DATA_W-1:0] operand,
  output logic [SUM_W-1:0]  sum,
  output logic              ovf
);

  localparam logic [SUM_W-1:0] MAX_V = SUM_W'(sat_max(SUM_W));
  localparam logic [SUM_W-1:0] MIN_V = SUM_W'(sat_min(SUM_W));

  logic [SUM_W-1:0] ext;
  logic [SUM_W:0]   wide;

  // One guard bit: overflow shows up as the top two bits disagreeing,
  // and the guard bit gives the true sign of the unclamped result.
  always_comb begin
    ext  = {{(SUM_W - DATA_W){operand[DATA_W-1]}}, operand};
    wide = {acc[SUM_W-1], acc} + {ext[SUM_W-1], ext};
    ovf  = wide[SUM_W] ^ wide[SUM_W-1];
    if (!ovf) begin
      sum = wide[SUM_W-1:0];
    end else if (wide[SUM_W]) begin
      sum = MIN_V;
    end else begin
      sum = MAX_V;
    end
  end

endmodule

// File: rtl/sub_diff_accum.sv
// Frame-level statistics over a stream of signed subtractor differences:
// saturating sum, negative-sample count and saturation flag per frame.
module sub_diff_accum
  import sub_pkg::*;
#(
  parameter int DATA_W    = DIFF_W,
  parameter int FRAME_LEN = 16,
  parameter int SUM_W     = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_diff,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [SUM_W-1:0]  sum_out,
  output logic [NEG_W-1:0]  neg_cnt,
  output logic              sat
);

  localparam logic [NEG_W-1:0] LAST_IDX = NEG_W'(FRAME_LEN - 1);

  logic [SUM_W-1:0] acc;
  logic [NEG_W-1:0] cnt;
  logic [NEG_W-1:0] neg_acc;
  logic             sat_acc;

  logic [SUM_W-1:0] add_sum;
  logic             add_ovf;
  logic [NEG_W-1:0] neg_next;
  logic             frame_last;
  logic             accept;

  sat_add_signed #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_sat_add (
    .acc     (acc),
    .operand (in_diff),
    .sum     (add_sum),
    .ovf     (add_ovf)
  );

  // Only the last sample of a frame can be stalled, and only while the
  // previous result is still waiting; sum_ready releases it in the same cycle.
  always_comb begin
    frame_last = (cnt == LAST_IDX);
    in_ready   = !(frame_last && sum_valid && !sum_ready);
    accept     = in_valid && in_ready;
    neg_next   = neg_acc + {{(NEG_W - 1){1'b0}}, in_diff[DATA_W-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      neg_acc   <= '0;
      sat_acc   <= 1'b0;
      sum_valid <= 1'b0;
      sum_out   <= '0;
      neg_cnt   <= '0;
      sat       <= 1'b0;
    end else begin
      if (sum_valid && sum_ready) begin
        sum_valid <= 1'b0;
      end
      // A frame end overrides the consume above so back-to-back results never lose valid.
      if (accept) begin
        if (frame_last) begin
          acc       <= '0;
          cnt       <= '0;
          neg_acc   <= '0;
          sat_acc   <= 1'b0;
          sum_out   <= add_sum;
          neg_cnt   <= neg_next;
          sat       <= sat_acc | add_ovf;
          sum_valid <= 1'b1;
        end else begin
          acc     <= add_sum;
          cnt     <= cnt + 1'b1;
          neg_acc <= neg_next;
          sat_acc <= sat_acc | add_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_sub_diff_accum.sv
// Self-checking bench: directed frames on short-frame instances plus a random
// handshake run on a 16-sample frame compared against an arithmetic scoreboard.
module tb_sub_diff_accum;

  localparam int RS_W         = 10;
  localparam int RAND_SAMPLES = 1008;
  localparam int RAND_MAX     = 2 ** (RS_W - 1) - 1;
  localparam int RAND_MIN     = -(2 ** (RS_W - 1));

  logic clk;
  logic rst_n;

  logic        a_valid, a_ready, a_svalid, a_sready, a_sat;
  logic [7:0]  a_diff, a_neg;
  logic [15:0] a_sum;

  logic        b_ready, b_svalid, b_sat;
  logic [7:0]  b_neg;
  logic [8:0]  b_sum;

  logic            r_valid, r_ready, r_svalid, r_sready, r_sat;
  logic [7:0]      r_diff, r_neg;
  logic [RS_W-1:0] r_sum;

  int tests_run;
  int tests_failed;

  typedef struct {
    int sum;
    int neg;
    bit sat;
  } frame_t;

  frame_t exp_q[$];

  sub_diff_accum #(.DATA_W(8), .FRAME_LEN(4), .SUM_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_diff(a_diff),
    .sum_valid(a_svalid), .sum_ready(a_sready), .sum_out(a_sum), .neg_cnt(a_neg), .sat(a_sat)
  );

  sub_diff_accum #(.DATA_W(8), .FRAME_LEN(4), .SUM_W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(b_ready), .in_diff(a_diff),
    .sum_valid(b_svalid), .sum_ready(a_sready), .sum_out(b_sum), .neg_cnt(b_neg), .sat(b_sat)
  );

  sub_diff_accum #(.DATA_W(8), .FRAME_LEN(16), .SUM_W(RS_W)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(r_valid), .in_ready(r_ready), .in_diff(r_diff),
    .sum_valid(r_svalid), .sum_ready(r_sready), .sum_out(r_sum), .neg_cnt(r_neg), .sat(r_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Offers one sample to the short-frame instances for exactly one edge.
  task automatic apply_stimulus(input logic [7:0] value);
    a_diff  = value;
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  initial begin
    int     cycles;
    int     samples;
    int     m_acc;
    int     m_cnt;
    int     m_neg;
    bit     m_sat;
    bit     exp_rdy;
    bit     take;
    bit     give;
    int     v;
    logic [7:0] d;
    frame_t f;

    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    a_valid = 1'b0; a_diff = 8'h00; a_sready = 1'b1;
    r_valid = 1'b0; r_diff = 8'h00; r_sready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    check_output("rst_sum_valid", 32'(a_svalid), 32'd0);
    check_output("rst_sum_out", 32'(a_sum), 32'd0);
    check_output("rst_neg_cnt", 32'(a_neg), 32'd0);
    check_output("rst_sat", 32'(a_sat), 32'd0);
    check_output("rst_in_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic frame: 5 + 3 - 2 + 1.
    apply_stimulus(8'h05);
    apply_stimulus(8'h03);
    apply_stimulus(8'hFE);
    apply_stimulus(8'h01);
    check_output("basic_valid", 32'(a_svalid), 32'd1);
    check_output("basic_sum", 32'(a_sum), 32'd7);
    check_output("basic_neg", 32'(a_neg), 32'd1);
    check_output("basic_sat", 32'(a_sat), 32'd0);
    check_output("basic_sum9", 32'(b_sum), 32'd7);
    @(posedge clk);
    #1;
    check_output("basic_valid_drop", 32'(a_svalid), 32'd0);

    // Most-negative samples: fits in 16 bits, clamps in 9 bits.
    repeat (4) apply_stimulus(8'h80);
    check_output("neg_sum16", 32'(a_sum), 32'h0000FE00);
    check_output("neg_cnt16", 32'(a_neg), 32'd4);
    check_output("neg_sat16", 32'(a_sat), 32'd0);
    check_output("neg_sum9", 32'(b_sum), 32'h00000100);
    check_output("neg_sat9", 32'(b_sat), 32'd1);
    check_output("neg_cnt9", 32'(b_neg), 32'd4);
    @(posedge clk);
    #1;

    // Backpressure: first result held, last sample of second frame stalls.
    a_sready = 1'b0;
    for (int i = 1; i <= 7; i++) apply_stimulus(8'(i));
    a_diff  = 8'd8;
    a_valid = 1'b1;
    #1;
    check_output("bp_ready_low", 32'(a_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_output("bp_hold_valid", 32'(a_svalid), 32'd1);
      check_output("bp_hold_sum", 32'(a_sum), 32'd10);
      check_output("bp_hold_ready", 32'(a_ready), 32'd0);
    end
    a_sready = 1'b1;
    #1;
    check_output("bp_release_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    check_output("bp_second_valid", 32'(a_svalid), 32'd1);
    check_output("bp_second_sum", 32'(a_sum), 32'd26);
    check_output("bp_second_neg", 32'(a_neg), 32'd0);
    check_output("bp_second_sum9", 32'(b_sum), 32'd26);
    @(posedge clk);
    #1;
    check_output("bp_drain", 32'(a_svalid), 32'd0);

    // Mid-frame asynchronous reset with a pending saturated result.
    a_sready = 1'b0;
    repeat (4) apply_stimulus(8'h80);
    check_output("pre_rst_valid", 32'(a_svalid), 32'd1);
    apply_stimulus(8'h01);
    apply_stimulus(8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("arst_valid", 32'(a_svalid), 32'd0);
    check_output("arst_sum", 32'(a_sum), 32'd0);
    check_output("arst_neg", 32'(a_neg), 32'd0);
    check_output("arst_sat9", 32'(b_sat), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a_sready = 1'b1;
    repeat (4) apply_stimulus(8'h01);
    check_output("post_rst_valid", 32'(a_svalid), 32'd1);
    check_output("post_rst_sum", 32'(a_sum), 32'd4);
    check_output("post_rst_neg", 32'(a_neg), 32'd0);

    // Random handshake run against an arithmetic scoreboard.
    cycles = 0; samples = 0;
    m_acc = 0; m_cnt = 0; m_neg = 0; m_sat = 1'b0;
    while (!(samples >= RAND_SAMPLES && exp_q.size() == 0) && cycles < 20000) begin
      r_valid  = (samples < RAND_SAMPLES) && ($urandom_range(0, 3) != 0);
      r_diff   = 8'($urandom);
      r_sready = ($urandom_range(0, 1) == 1);
      #1;
      check_output("rand_sum_valid", 32'(r_svalid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check_output("rand_sum", 32'(r_sum), 32'(exp_q[0].sum[RS_W-1:0]));
        check_output("rand_neg", 32'(r_neg), 32'(exp_q[0].neg[7:0]));
        check_output("rand_sat", 32'(r_sat), 32'(exp_q[0].sat));
      end
      exp_rdy = !(m_cnt == 15 && exp_q.size() != 0 && !r_sready);
      check_output("rand_in_ready", 32'(r_ready), 32'(exp_rdy));
      take = r_valid && exp_rdy;
      give = (exp_q.size() != 0) && r_sready;
      d = r_diff;
      @(posedge clk);
      #1;
      if (give) void'(exp_q.pop_front());
      if (take) begin
        samples++;
        v = m_acc + int'($signed(d));
        if (v > RAND_MAX) begin v = RAND_MAX; m_sat = 1'b1; end
        if (v < RAND_MIN) begin v = RAND_MIN; m_sat = 1'b1; end
        m_acc = v;
        m_neg += int'(d[7]);
        m_cnt++;
        if (m_cnt == 16) begin
          f.sum = m_acc; f.neg = m_neg; f.sat = m_sat;
          exp_q.push_back(f);
          m_acc = 0; m_cnt = 0; m_neg = 0; m_sat = 1'b0;
        end
      end
      cycles++;
    end
    check_output("rand_done", 32'(samples >= RAND_SAMPLES && exp_q.size() == 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
